// File: rtl/dmem_copy_initiator.sv
// Word-by-word memory copy engine: read a word, capture it, write it, repeat for len words.
// Optional running XOR of copied words when DMEM_COPY_CHECKSUM_EN is defined.
module dmem_copy_initiator #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  output logic              memwrite,
  output logic              memread,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_CAP = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [ADDR_W-1:0] remaining_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] buffer_reg;
  logic              accept;
  logic              last_word;

  assign accept    = (state_reg == IDLE) && start;
  assign last_word = (remaining_reg == ADDR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strobes are decoded from the state so an asynchronous reset drops them at once.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len != '0) ? RD : DONE;
        end
      end
      RD: begin
        busy       = 1'b1;
        memread    = 1'b1;
        state_next = RD_CAP;
      end
      RD_CAP: begin
        busy       = 1'b1;
        memread    = 1'b1;
        state_next = WR;
      end
      WR: begin
        busy       = 1'b1;
        memwrite   = 1'b1;
        state_next = last_word ? DONE : RD;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // addr is loaded one state ahead so it is already valid when the strobe rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      addr_reg      <= '0;
      buffer_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && (len != '0)) begin
            src_reg       <= src_addr;
            dst_reg       <= dst_addr;
            remaining_reg <= len;
            addr_reg      <= src_addr;
          end
        end
        RD_CAP: begin
          buffer_reg <= read_data;
          addr_reg   <= dst_reg;
        end
        WR: begin
          src_reg       <= src_reg + ADDR_W'(1);
          dst_reg       <= dst_reg + ADDR_W'(1);
          remaining_reg <= remaining_reg - ADDR_W'(1);
          if (!last_word) begin
            addr_reg <= src_reg + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign addr       = addr_reg;
  assign write_data = buffer_reg;

`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= '0;
    end else if (state_reg == RD_CAP) begin
      checksum_reg <= checksum_reg ^ read_data;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_copy_initiator.sv
// Bench for dmem_copy_initiator: table of directed copies, reset abort, start-while-busy,
// and random copies checked against an array-based reference of the copy rules.
module tb_dmem_copy_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic [7:0]  addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [31:0] read_data = '0;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  dmem_copy_initiator #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .read_data(read_data), .checksum(checksum)
  );

  // Memory with one-cycle read latency plus a bench-side preload port.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (memwrite) mem[addr] <= write_data;
    if (memread) read_data <= mem[addr];
  end

  // Monitor: append-only logs and running counters sampled mid-cycle.
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          rdcyc_cnt = 0;
  int          clash_cnt = 0;
  logic        rd_prev = 1'b0;
  logic [7:0]  rd_log[$];
  logic [39:0] wr_log[$];

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (memread) rdcyc_cnt <= rdcyc_cnt + 1;
    if (memread && memwrite) clash_cnt <= clash_cnt + 1;
    if (memread && !rd_prev) rd_log.push_back(addr);
    if (memwrite) wr_log.push_back({addr, write_data});
    rd_prev <= memread;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_mem(input string tag);
    int mm;
    mm = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mm++;
    check({tag, " mem mismatches"}, 64'(mm), 64'd0);
  endtask

  // One copy: reference model first, then drive, then compare logs and counters.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input bit interfere, input int exp_lat, input string tag);
    logic [7:0]  exp_rd[$];
    logic [39:0] exp_wr[$];
    logic [31:0] cks;
    logic [31:0] exp_cks;
    logic [7:0]  sa;
    logic [7:0]  da;
    int rd0, wr0, busy0, done0, rdc0, clash0, lat;

    cks = '0;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      exp_rd.push_back(sa);
      exp_wr.push_back({da, ref_mem[sa]});
      cks ^= ref_mem[sa];
      ref_mem[da] = ref_mem[sa];
    end
`ifdef DMEM_COPY_CHECKSUM_EN
    exp_cks = cks;
`else
    exp_cks = '0;
`endif

    rd0 = rd_log.size(); wr0 = wr_log.size();
    busy0 = busy_cnt; done0 = done_cnt; rdc0 = rdcyc_cnt; clash0 = clash_cnt;

    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = interfere;
    lat = 0;
    while (!done && lat < 800) begin
      if (interfere && lat < 4) begin
        start = 1'b1; src_addr = s ^ 8'h5A; dst_addr = d ^ 8'hA5; len = l + 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " done seen"}, 64'(done), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    check({tag, " done width"}, 64'(done), 64'd0);
    check({tag, " done pulses"}, 64'(done_cnt - done0), 64'd1);
    check({tag, " busy cycles"}, 64'(busy_cnt - busy0), 64'(3 * int'(l)));
    check({tag, " read cycles"}, 64'(rdcyc_cnt - rdc0), 64'(2 * int'(l)));
    check({tag, " rd/wr clash"}, 64'(clash_cnt - clash0), 64'd0);
    check({tag, " read count"}, 64'(rd_log.size() - rd0), 64'(exp_rd.size()));
    check({tag, " write count"}, 64'(wr_log.size() - wr0), 64'(exp_wr.size()));
    if (rd_log.size() - rd0 == exp_rd.size())
      for (int i = 0; i < exp_rd.size(); i++)
        check({tag, " read addr"}, 64'(rd_log[rd0 + i]), 64'(exp_rd[i]));
    if (wr_log.size() - wr0 == exp_wr.size())
      for (int i = 0; i < exp_wr.size(); i++)
        check({tag, " write addr/data"}, 64'(wr_log[wr0 + i]), 64'(exp_wr[i]));
    check({tag, " checksum"}, 64'(checksum), 64'(exp_cks));
    check_mem(tag);
    $display("xfer %s src=%02h dst=%02h len=%0d lat=%0d cks=%08h", tag, s, d, l, lat, checksum);
  endtask

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [7:0]  len;
    bit          interfere;
    int          exp_lat;
    bit          chk_cks;
    logic [31:0] exp_cks;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] v;
    logic [31:0] tbl_cks;
    int nw, cyc;

    vecs[0] = '{8'h10, 8'h20, 8'd1, 1'b0, 3,  1'b1, 32'h16A};
    vecs[1] = '{8'h08, 8'h40, 8'd4, 1'b0, 12, 1'b1, 32'h4};
    vecs[2] = '{8'hFE, 8'h80, 8'd3, 1'b0, 9,  1'b0, 32'h0};
    vecs[3] = '{8'h55, 8'h66, 8'd0, 1'b0, 0,  1'b1, 32'h0};
    vecs[4] = '{8'h30, 8'h31, 8'd4, 1'b0, 12, 1'b0, 32'h0};
    vecs[5] = '{8'h70, 8'h90, 8'd3, 1'b1, 9,  1'b0, 32'h0};

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;

    // Preload memory while held in reset.
    pre_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      if (i == 8'h10) v = 32'h16A;
      if (i >= 8'h08 && i <= 8'h0B) v = 32'(i - 7);
      pre_addr = 8'(i); pre_data = v; ref_mem[i] = v;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset memread", 64'(memread), 64'd0);
    check("reset memwrite", 64'(memwrite), 64'd0);
    check("reset addr", 64'(addr), 64'd0);
    check("reset write_data", 64'(write_data), 64'd0);
    check("reset checksum", 64'(checksum), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].interfere, vecs[i].exp_lat,
               $sformatf("vec%0d", i));
`ifdef DMEM_COPY_CHECKSUM_EN
      tbl_cks = vecs[i].exp_cks;
`else
      tbl_cks = '0;
`endif
      if (vecs[i].chk_cks) check($sformatf("vec%0d table checksum", i), 64'(checksum), 64'(tbl_cks));
    end

    // Reset pulsed during the write of word 2 of 4.
    begin
      int wr0, done0;
      wr0 = wr_log.size(); done0 = done_cnt;
      src_addr = 8'h50; dst_addr = 8'hC0; len = 8'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nw = 0; cyc = 0;
      while (nw < 2 && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
        if (memwrite) nw++;
      end
      check("abort reached word2 write", 64'(nw), 64'd2);
      #1 rst_n = 1'b0;
      #1;
      check("abort memwrite drop", 64'(memwrite), 64'd0);
      check("abort memread", 64'(memread), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      check("abort addr", 64'(addr), 64'd0);
      check("abort write_data", 64'(write_data), 64'd0);
      check("abort checksum", 64'(checksum), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      ref_mem[8'hC0] = ref_mem[8'h50];
      check("abort done pulses", 64'(done_cnt - done0), 64'd0);
      check("abort writes", 64'(wr_log.size() - wr0), 64'd1);
      check_mem("abort");
      $display("xfer abort src=50 dst=c0 len=4 writes=%0d", wr_log.size() - wr0);
    end

    run_copy(8'h50, 8'hC0, 8'd4, 1'b0, 12, "after_abort");

    for (int i = 0; i < 16; i++) begin
      logic [7:0] s, d, l;
      bit itf;
      s = 8'($urandom); d = 8'($urandom); l = 8'($urandom_range(0, 10));
      itf = (l >= 8'd2) && ($urandom_range(0, 1) == 1);
      run_copy(s, d, l, itf, 3 * int'(l), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_copy_initiator.md
DMEM_COPY_INITIATOR -- requirements
Module: dmem_copy_initiator

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the memory word width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request to begin a copy, sampled in IDLE only.
REQ-006 The block SHALL have port src_addr  input  ADDR_W  first source word address, sampled with start.
REQ-007 The block SHALL have port dst_addr  input  ADDR_W  first destination word address, sampled with start.
REQ-008 The block SHALL have port len  input  ADDR_W  number of words to copy, sampled with start.
REQ-009 The block SHALL have port busy  output  1  high while a copy is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port addr  output  ADDR_W  memory address.
REQ-012 The block SHALL have port write_data  output  DATA_W  memory write data.
REQ-013 The block SHALL have port memwrite  output  1  memory write strobe.
REQ-014 The block SHALL have port memread  output  1  memory read enable.
REQ-015 The block SHALL have port read_data  input  DATA_W  memory read data.
REQ-016 The block SHALL have port checksum  output  DATA_W  XOR of all words copied in the current or last transfer.

Function
REQ-017 The block SHALL implement FSM states IDLE, RD, RD_CAP, WR and DONE.
REQ-018 In IDLE with start=1 and len!=0, the block SHALL latch src_addr, dst_addr and len, then go to RD.
REQ-019 In IDLE with start=1 and len=0, the block SHALL go to DONE with no memory access.
REQ-020 In RD, the block SHALL drive addr=current source address and memread=1, then go to RD_CAP.
REQ-021 In RD_CAP, the block SHALL keep memread=1 and addr unchanged, latch read_data into the word buffer at the end of the cycle (1-cycle read latency), then go to WR.
REQ-022 In WR, the block SHALL drive addr=current destination address, write_data=buffer and memwrite=1 for exactly one cycle.
REQ-023 At the end of WR, the block SHALL increment both addresses, decrement the remaining count, and go to RD if the remaining count is nonzero, else to DONE.
REQ-024 In DONE, the block SHALL assert done=1 for one cycle, then return to IDLE.
REQ-025 memread and memwrite SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DONE.
REQ-026 busy SHALL be 1 in RD, RD_CAP and WR, and 0 in IDLE and DONE.
REQ-027 A transfer of N words SHALL take exactly 3N cycles from start acceptance to the done pulse cycle.
REQ-028 Address increments SHALL wrap modulo 2^ADDR_W; for example, 8'hFF+1 = 8'h00.
REQ-029 len SHALL be treated as unsigned, so len=8'hFF copies 255 words.
REQ-030 start asserted outside IDLE SHALL be ignored, and the latched parameters SHALL be unaffected.
REQ-031 Overlapping source and destination ranges SHALL be copied strictly forward, one word at a time, with no overlap correction.
REQ-032 In idle states, addr and write_data SHALL hold their last driven values.

Reset
REQ-033 On rst_n=0, the block SHALL asynchronously set state=IDLE, busy=0, done=0, memread=0, memwrite=0, addr=0, write_data=0, buffer=0 and checksum=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer immediately, with no further memory access and no done pulse.

Configuration
REQ-035 With DMEM_COPY_CHECKSUM_EN defined, checksum SHALL be cleared on start acceptance and XORed with each buffered word at the end of RD_CAP.
REQ-036 Without DMEM_COPY_CHECKSUM_EN, checksum SHALL be constant 0 and no checksum register SHALL be synthesized.

Verification
REQ-037 The bench SHALL cover: preload mem[8'h10]=32'h16A; start src=8'h10, dst=8'h20, len=1 -> memwrite high exactly 1 cycle with addr=8'h20 and write_data=32'h16A; done 3 cycles after start acceptance.
REQ-038 The bench SHALL cover: mem[8'h08..8'h0B]=1,2,3,4; copy to 8'h40, len=4 -> mem[8'h40..8'h43]=1,2,3,4; done 12 cycles after start acceptance; checksum=32'h4 when enabled.
REQ-039 The bench SHALL cover: src=8'hFE, dst=8'h80, len=3 -> reads from addresses FE, FF, 00 in that order.
REQ-040 The bench SHALL cover: len=0 -> done in the cycle after acceptance; memread and memwrite never asserted; busy stays 0.
REQ-041 The bench SHALL cover: rst_n pulsed low during WR of word 2 of 4 -> memwrite drops immediately, no done pulse, and the next start runs normally.
REQ-042 The bench SHALL cover: start re-asserted while busy with different src -> ignored; the original transfer completes unchanged.
